// File: rtl/pad_cell_output_bank.sv
// pad_cell_output_bank
// Simulation model of a bank of output-only pad cells. Each channel takes a
// requested {drive, enable} pair from the pad controller and applies it to its
// pin after a programmable slew latency. It supports open-drain signalling,
// a loopback readback of the resolved pin and a saturating count of drive
// transitions. Channels are independent of each other.
//
// Attribute layout per pad (bits beyond PADATTR read as 0):
//   [2:0] slew code s (effective delay d = min(s, MAX_SLEW))
//   [3]   open-drain enable
//   [4]   loopback enable
//   rest  reserved, ignored

module pad_cell_output_bank #(
    parameter int NUM_PADS    = 4,
    parameter int PADATTR     = 16,
    parameter int MAX_SLEW    = 7,
    parameter int CNT_W       = 16,
    parameter int PADATTR_RND = (PADATTR == 0) ? 1 : PADATTR
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PADS-1:0]             pad_in_i,
    input  logic [NUM_PADS-1:0]             pad_oe_i,
    input  logic [NUM_PADS*PADATTR_RND-1:0] pad_attributes_i,
    output logic [NUM_PADS-1:0]             pad_out_o,
    inout  wire  [NUM_PADS-1:0]             pad_io,
    output logic [NUM_PADS-1:0]             busy_o,
    output logic [NUM_PADS*CNT_W-1:0]       toggle_cnt_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    // Slew codes above this ceiling are clamped to it.
    localparam logic [2:0]       SLEW_CAP = 3'(MAX_SLEW);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad

        logic [PADATTR_RND-1:0] attr_raw;
        logic [4:0]             attr;
        logic [2:0]             slew;
        logic                   od;
        logic                   lb;
        logic [1:0]             req;       // {drive, enable} requested this cycle
        logic                   drive_en;
        logic                   unused_attr;

        state_e           state_q, state_d;
        logic             drv_q,   drv_d;
        logic             oe_q,    oe_d;
        logic [1:0]       tgt_q,   tgt_d;  // {drive, enable} waiting to be applied
        logic [2:0]       cnt_q,   cnt_d;  // settle cycles remaining
        logic [CNT_W-1:0] tog_q,   tog_d;

        assign attr_raw    = pad_attributes_i[p*PADATTR_RND +: PADATTR_RND];
        // Reserved attribute bits are deliberately ignored.
        assign unused_attr = ^attr_raw;

        // Zero-extend the attribute field so narrow or empty configurations read 0.
        always_comb begin
            // NOTE: every combinational output gets a default first so no path
            // leaves it unassigned, which would otherwise infer a latch.
            attr = '0;
            for (int b = 0; b < 5; b++) begin
                if (b < PADATTR) begin
                    attr[b] = attr_raw[b];
                end
            end
        end

        assign slew = (attr[2:0] > SLEW_CAP) ? SLEW_CAP : attr[2:0];
        assign od   = attr[3];
        assign lb   = attr[4];
        assign req  = {pad_in_i[p], pad_oe_i[p]};

        // Next-state logic: immediate apply, settle countdown and retargeting.
        always_comb begin
            state_d = state_q;
            drv_d   = drv_q;
            oe_d    = oe_q;
            tgt_d   = tgt_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (req != {drv_q, oe_q}) begin
                        if (slew == 3'd0) begin
                            {drv_d, oe_d} = req;
                        end else begin
                            tgt_d   = req;
                            cnt_d   = slew;
                            state_d = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (req != tgt_q) begin
                        // A zero-delay retarget behaves like the zero-delay
                        // idle path: apply now rather than load an empty count.
                        if (slew == 3'd0) begin
                            {drv_d, oe_d} = req;
                            state_d       = ST_IDLE;
                        end else begin
                            tgt_d = req;
                            cnt_d = slew;
                        end
                    end else if (cnt_q == 3'd1) begin
                        {drv_d, oe_d} = tgt_q;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Transition counter: count applied drive changes while enabled, saturating.
        always_comb begin
            tog_d = tog_q;
            if ((drv_d != drv_q) && oe_d && (tog_q != CNT_MAX)) begin
                tog_d = tog_q + CNT_W'(1);
            end
        end

        // State registers; reset discards any pending target.
        always_ff @(posedge clk_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (rst_i) begin
                state_q <= ST_IDLE;
                drv_q   <= 1'b0;
                oe_q    <= 1'b0;
                tgt_q   <= 2'b00;
                cnt_q   <= 3'd0;
                tog_q   <= '0;
            end else begin
                state_q <= state_d;
                drv_q   <= drv_d;
                oe_q    <= oe_d;
                tgt_q   <= tgt_d;
                cnt_q   <= cnt_d;
                tog_q   <= tog_d;
            end
        end

        // An open-drain pad releases the pin instead of driving a high.
        assign drive_en  = oe_q & ~(od & drv_q);
        assign pad_io[p] = drive_en ? drv_q : 1'bz;

        assign pad_out_o[p]                     = lb & pad_io[p];
        assign busy_o[p]                        = (state_q == ST_SETTLE);
        assign toggle_cnt_o[p*CNT_W +: CNT_W]   = tog_q;
    end

endmodule
